// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite responder backed by a word-organised on-chip SRAM.
//   The slave accepts pipelined address phases and inserts WAIT_STATES wait
//   cycles into every OKAY data phase. It writes byte, halfword or word lanes
//   and returns whole-word reads. Misaligned or oversized transfers receive
//   the two-cycle ERROR response and never touch memory.
//
// Parameters
//   ADDR_WIDTH   word-address bits; HADDR[ADDR_WIDTH+1:2] indexes memory
//   WAIT_STATES  wait cycles per OKAY data phase (0..15)
//
// Ports
//   HCLK       in   clock, all state on rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   transfer address
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HSIZE      in   000 byte, 001 halfword, 010 word
//   HBURST     in   ignored; every beat is handled independently
//   HWRITE     in   1 = write
//   HWDATA     in   write data (data phase)
//   HREADY     in   bus-level ready
//   HREADYOUT  out  this slave's ready (registered)
//   HRDATA     out  read data (combinational from memory)
//   HRESP      out  0 OKAY, 1 ERROR (registered)
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [2:0]            r_size;
  logic                  r_write;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_accept;
  logic                  w_err;
  logic [3:0]            w_lane;
  logic                  w_unused;

  // Only states that drive HREADYOUT high can start a new transfer.
  assign w_accept = HSEL & HREADY & HTRANS[1] & r_hreadyout;

  assign w_err = HSIZE[2] | (HSIZE == 3'b011)
               | ((HSIZE == 3'b001) & HADDR[0])
               | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

  assign w_unused = ^{HBURST, HADDR[31:ADDR_WIDTH+2]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all evaluate a new address phase identically.
          if (w_accept) begin
            r_addr  <= HADDR[ADDR_WIDTH+1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= 4'(WAIT_STATES - 1);
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Little-endian lane select; only legal sizes ever reach S_DATA.
  always_comb begin
    w_lane = '0;
    case (r_size)
      3'b000: w_lane[r_addr[1:0]] = 1'b1;
      3'b001: begin
        w_lane[{r_addr[1], 1'b0}] = 1'b1;
        w_lane[{r_addr[1], 1'b1}] = 1'b1;
      end
      default: w_lane = '1;
    endcase
  end

  // Memory has no reset; commit happens on the edge that ends the data phase.
  always_ff @(posedge HCLK) begin
    if (r_state == S_DATA && r_write) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_lane[k]) begin
          r_mem[r_addr[ADDR_WIDTH+1:2]][8*k +: 8] <= HWDATA[8*k +: 8];
        end
      end
    end
  end

  assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[r_addr[ADDR_WIDTH+1:2]] : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    int unsigned waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic        hwrite = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  hro;
  logic [2:0]  hresp;
  logic [2:0]  hrdy;
  logic [31:0] hrd [3];

  int errs = 0;
  int checks = 0;

  xfer_t       stim [$];
  exp_t        exp_q [$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  assign hrdy[0] = hro[0] & ~stall;
  assign hrdy[1] = hro[1] & ~stall;
  assign hrdy[2] = hro[2] & ~stall;

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hrdy[0]),
    .HREADYOUT(hro[0]), .HRDATA(hrd[0]), .HRESP(hresp[0]));

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hrdy[1]),
    .HREADYOUT(hro[1]), .HRDATA(hrd[1]), .HRESP(hresp[1]));

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hrdy[2]),
    .HREADYOUT(hro[2]), .HRDATA(hrd[2]), .HRESP(hresp[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    stim.push_back(x);
  endtask

  // Reference model: decide the response and apply writes in bus order.
  task automatic push_expect(input int d, input xfer_t x, input int unsigned ws);
    exp_t        e;
    int          key;
    int          base;
    logic [31:0] cur;
    e.err = (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
            (x.size == 3'd2 && x.addr[1:0] != 2'b00);
    e.wr    = x.wr;
    e.waits = e.err ? 1 : ws;
    e.rdata = '0;
    key = d * 4096 + int'(x.addr[11:2]);
    if (!e.err) begin
      if (x.wr) begin
        cur = mdl.exists(key) ? mdl[key] : 32'h0;
        case (x.size)
          3'd0: begin
            base = int'(x.addr[1:0]);
            cur[8*base +: 8] = x.wdata[8*base +: 8];
          end
          3'd1: begin
            base = x.addr[1] ? 2 : 0;
            cur[8*base +: 16] = x.wdata[8*base +: 16];
          end
          default: cur = x.wdata;
        endcase
        mdl[key] = cur;
      end else begin
        e.rdata = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
      end
    end
    exp_q.push_back(e);
  endtask

  // Pipelined AHB master driving the queued stimulus into slave d.
  task automatic run_seq(input int d, input int unsigned ws, output int dp_cyc);
    xfer_t ap, dp;
    exp_t  e;
    bit    ap_v = 0, dp_v = 0, prev_rdy = 1;
    int    stl = 0, cyc = 0;
    dp_cyc = 0;
    exp_q.delete();
    ap = '{default: '0};
    dp = '{default: '0};
    e  = '{default: '0};
    while ((stim.size() > 0 || ap_v || dp_v) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_rdy) begin
        dp_v = ap_v && ap.trans[1];
        dp   = ap;
        if (dp_v) begin
          e   = exp_q.pop_front();
          stl = 0;
        end
        if (stim.size() > 0) begin
          ap   = stim.pop_front();
          ap_v = 1;
          if (ap.trans[1]) push_expect(d, ap, ws);
        end else begin
          ap_v = 0;
        end
      end
      sel[d] = ap_v;
      htrans = ap_v ? ap.trans : 2'b00;
      haddr  = ap.addr;
      hwrite = ap.wr;
      hsize  = ap.size;
      hwdata = dp_v ? dp.wdata : 32'h0;
      if (dp_v) begin
        dp_cyc++;
        if (hro[d]) begin
          chk($sformatf("d%0d resp@%h", d, dp.addr), 32'(hresp[d]), 32'(e.err));
          chk($sformatf("d%0d stall@%h", d, dp.addr), 32'(stl), 32'(e.waits));
          if (!e.wr && !e.err)
            chk($sformatf("d%0d rdata@%h", d, dp.addr), hrd[d], e.rdata);
        end else begin
          chk($sformatf("d%0d waitresp@%h", d, dp.addr), 32'(hresp[d]), 32'(e.err));
          stl++;
        end
      end else begin
        chk($sformatf("d%0d idle_rdy", d), 32'(hro[d]), 32'd1);
        chk($sformatf("d%0d idle_resp", d), 32'(hresp[d]), 32'd0);
      end
      prev_rdy = hro[d];
    end
    if (stim.size() > 0 || ap_v || dp_v) chk("seq_timeout", 32'd1, 32'd0);
    stim.delete();
    sel    = '0;
    htrans = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state of all three slaves.
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), 32'(hro[i]), 32'd1);
      chk($sformatf("rst_resp%0d", i), 32'(hresp[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), hrd[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Zero wait states: pipelined write/read, byte lane, errors, idle/busy.
    add(2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(2'b10, 1, 32'h13, 3'd0, 32'hAA000000);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(2'b10, 1, 32'h11, 3'd1, 32'h55555555);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(2'b10, 1, 32'h20, 3'd3, 32'h12121212);
    add(2'b00, 1, 32'h10, 3'd2, 32'h0);
    add(2'b01, 1, 32'h10, 3'd2, 32'h0);
    add(2'b10, 1, 32'h26, 3'd1, 32'hBEEF0000);
    add(2'b10, 1, 32'h24, 3'd1, 32'h0000CAFE);
    add(2'b10, 0, 32'h24, 3'd2, 32'h0);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    run_seq(0, 0, n);

    // Another slave stalls HREADY: nothing sampled.
    @(posedge clk); #1;
    stall = 1'b1; sel[0] = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 32'h10; hsize = 3'd2; hwdata = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_rdy", 32'(hro[0]), 32'd1);
      chk("stall_resp", 32'(hresp[0]), 32'd0);
    end
    stall = 1'b0; sel[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("nosel_rdy", 32'(hro[0]), 32'd1);
      chk("nosel_resp", 32'(hresp[0]), 32'd0);
    end
    htrans = 2'b00;
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    run_seq(0, 0, n);

    // Two wait states.
    add(2'b10, 1, 32'h10, 3'd2, 32'h11112222);
    add(2'b10, 1, 32'h14, 3'd2, 32'h33334444);
    add(2'b10, 1, 32'h18, 3'd2, 32'h55556666);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(2'b10, 1, 32'h11, 3'd1, 32'hFFFFFFFF);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    run_seq(1, 2, n);
    add(2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(2'b11, 0, 32'h14, 3'd2, 32'h0);
    add(2'b11, 0, 32'h18, 3'd2, 32'h0);
    run_seq(1, 2, n);
    chk("burst3_cycles", 32'(n), 32'd9);

    // Three wait states; reset during the second wait cycle drops the write.
    add(2'b10, 1, 32'h40, 3'd2, 32'h12345678);
    run_seq(2, 3, n);
    @(posedge clk); #1;
    sel[2] = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
    @(posedge clk); #1;
    chk("ws3_wait1", 32'(hro[2]), 32'd0);
    sel[2] = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("ws3_wait2", 32'(hro[2]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(hro[2]), 32'd1);
    chk("midrst_resp", 32'(hresp[2]), 32'd0);
    chk("midrst_rdata", hrd[2], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    add(2'b10, 0, 32'h40, 3'd2, 32'h0);
    run_seq(2, 3, n);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
